// File: rtl/uart_mem_sequencer_pkg.sv
// Shared command codes and FSM state type for the UART/memory sequencer.
// UART_MEM_CHECKSUM_EN adds the two checksum transmit states.
package uart_mem_sequencer_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_TX_SEND,
        ST_TX_WAIT
`ifdef UART_MEM_CHECKSUM_EN
        ,
        ST_CK_SEND,
        ST_CK_WAIT
`endif
    } state_t;

endpackage

// File: rtl/uart_word_packer.sv
// Byte<->word shift buffer, LSB byte first; shared by the write-packing and
// read-unpacking paths of the sequencer.
module uart_word_packer #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [7:0]       i_byte,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_word,
    input  logic             i_shift,
    output logic [WIDTH-1:0] o_word,
    output logic [7:0]       o_next_byte,
    output logic             o_last
);

    localparam int BPW = WIDTH / 8;
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(BPW - 1);

    logic [WIDTH-1:0] r_buf;
    logic [CW-1:0]    r_byte_cnt;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_ins;
    logic [CW-1:0]    w_cnt_inc;

    // Both directions shift right: pushed bytes enter at the top, so after
    // BPW pushes byte 0 sits in bits [7:0].
    assign w_shifted = r_buf >> 8;
    assign w_ins     = WIDTH'(i_byte) << (WIDTH - 8);
    assign w_cnt_inc = (r_byte_cnt == LAST_IDX) ? '0 : r_byte_cnt + 1'b1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_buf      <= '0;
            r_byte_cnt <= '0;
        end else if (i_clr) begin
            r_buf      <= '0;
            r_byte_cnt <= '0;
        end else if (i_load) begin
            r_buf      <= i_word;
            r_byte_cnt <= '0;
        end else if (i_push) begin
            r_buf      <= w_shifted | w_ins;
            r_byte_cnt <= w_cnt_inc;
        end else if (i_shift) begin
            r_buf      <= w_shifted;
            r_byte_cnt <= w_cnt_inc;
        end
    end

    assign o_word      = r_buf;
    assign o_next_byte = w_shifted[7:0];
    assign o_last      = (r_byte_cnt == LAST_IDX);

endmodule

// File: rtl/uart_mem_sequencer.sv
// Command sequencer between UART RX/TX and a single-port word memory ('W' write, 'R' read).
// Optional UART_MEM_CHECKSUM_EN appends an XOR checksum/ack byte to each transaction.
module uart_mem_sequencer
    import uart_mem_sequencer_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 8,
    parameter int N_WORDS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_data,
    input  logic             rx_done,
    input  logic             tx_done,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    output logic [DEPTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_data,
    output logic             mem_wr_en,
    input  logic [WIDTH-1:0] mem_q,
    output logic             busy,
    output logic             done,
    output logic             cmd_err
);

    localparam logic [DEPTH:0] LAST_WORD = (DEPTH + 1)'(N_WORDS - 1);

    state_t           r_state;
    logic [DEPTH:0]   r_word_cnt;
    logic [DEPTH-1:0] r_mem_addr;
    logic             r_tx_start;
    logic [7:0]       r_tx_data;
    logic             r_wr_en;
    logic             r_done;
    logic             r_cmd_err;
`ifdef UART_MEM_CHECKSUM_EN
    logic [7:0]       r_xor;
`endif

    logic             w_pk_clr;
    logic             w_pk_push;
    logic             w_pk_load;
    logic             w_pk_shift;
    logic             w_pk_last;
    logic [WIDTH-1:0] w_pk_word;
    logic [7:0]       w_pk_next_byte;
    logic             w_last_word;
    logic [DEPTH:0]   w_word_inc;

    assign w_pk_clr    = (r_state == ST_IDLE) && rx_done && (rx_data == CMD_WRITE);
    assign w_pk_push   = (r_state == ST_LOAD) && rx_done;
    assign w_pk_load   = (r_state == ST_RD_WAIT);
    assign w_pk_shift  = (r_state == ST_TX_WAIT) && tx_done && !w_pk_last;
    assign w_last_word = (r_word_cnt == LAST_WORD);
    assign w_word_inc  = r_word_cnt + 1'b1;

    uart_word_packer #(
        .WIDTH(WIDTH)
    ) u_packer (
        .i_clk       (clk),
        .i_rst_n     (reset),
        .i_clr       (w_pk_clr),
        .i_push      (w_pk_push),
        .i_byte      (rx_data),
        .i_load      (w_pk_load),
        .i_word      (mem_q),
        .i_shift     (w_pk_shift),
        .o_word      (w_pk_word),
        .o_next_byte (w_pk_next_byte),
        .o_last      (w_pk_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_word_cnt <= '0;
            r_mem_addr <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_wr_en    <= 1'b0;
            r_done     <= 1'b0;
            r_cmd_err  <= 1'b0;
`ifdef UART_MEM_CHECKSUM_EN
            r_xor      <= '0;
`endif
        end else begin
            r_tx_start <= 1'b0;
            r_wr_en    <= 1'b0;
            r_done     <= 1'b0;
            r_cmd_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (rx_done) begin
`ifdef UART_MEM_CHECKSUM_EN
                        r_xor <= '0;
`endif
                        if (rx_data == CMD_WRITE) begin
                            r_state    <= ST_LOAD;
                            r_word_cnt <= '0;
                        end else if (rx_data == CMD_READ) begin
                            r_state    <= ST_RD_ADDR;
                            r_word_cnt <= '0;
                            r_mem_addr <= '0;
                        end else begin
                            r_cmd_err <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (rx_done) begin
`ifdef UART_MEM_CHECKSUM_EN
                        r_xor <= r_xor ^ rx_data;
`endif
                        // Write strobe lands the cycle after the last byte; the
                        // packer is free to accept byte 0 of the next word then.
                        if (w_pk_last) begin
                            r_wr_en    <= 1'b1;
                            r_mem_addr <= r_word_cnt[DEPTH-1:0];
                            r_word_cnt <= w_word_inc;
                            if (w_last_word) begin
`ifdef UART_MEM_CHECKSUM_EN
                                r_state    <= ST_CK_SEND;
                                r_tx_start <= 1'b1;
                                r_tx_data  <= r_xor ^ rx_data;
`else
                                r_state <= ST_IDLE;
                                r_done  <= 1'b1;
`endif
                            end
                        end
                    end
                end
                ST_RD_ADDR: r_state <= ST_RD_WAIT;
                ST_RD_WAIT: begin
                    r_state    <= ST_TX_SEND;
                    r_tx_start <= 1'b1;
                    r_tx_data  <= mem_q[7:0];
                end
                ST_TX_SEND: r_state <= ST_TX_WAIT;
                ST_TX_WAIT: begin
                    if (tx_done) begin
`ifdef UART_MEM_CHECKSUM_EN
                        r_xor <= r_xor ^ r_tx_data;
`endif
                        if (!w_pk_last) begin
                            r_state    <= ST_TX_SEND;
                            r_tx_start <= 1'b1;
                            r_tx_data  <= w_pk_next_byte;
                        end else if (!w_last_word) begin
                            r_state    <= ST_RD_ADDR;
                            r_word_cnt <= w_word_inc;
                            r_mem_addr <= w_word_inc[DEPTH-1:0];
                        end else begin
`ifdef UART_MEM_CHECKSUM_EN
                            r_state    <= ST_CK_SEND;
                            r_tx_start <= 1'b1;
                            r_tx_data  <= r_xor ^ r_tx_data;
`else
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
`endif
                        end
                    end
                end
`ifdef UART_MEM_CHECKSUM_EN
                ST_CK_SEND: r_state <= ST_CK_WAIT;
                ST_CK_WAIT: begin
                    if (tx_done) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign tx_start  = r_tx_start;
    assign tx_data   = r_tx_data;
    assign mem_addr  = r_mem_addr;
    assign mem_data  = w_pk_word;
    assign mem_wr_en = r_wr_en;
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign cmd_err   = r_cmd_err;

endmodule

// File: tb/tb_uart_mem_sequencer.sv
// Scoreboard bench for uart_mem_sequencer: a transaction-level model queues
// expected writes/TX bytes, a monitor pops and compares on DUT strobes.
module tb_uart_mem_sequencer;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 8;
    localparam int N_WORDS = 8;
    localparam int BPW     = WIDTH / 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [7:0]       rx_data;
    logic             rx_done;
    logic             tx_done;
    logic             tx_start;
    logic [7:0]       tx_data;
    logic [DEPTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_data;
    logic             mem_wr_en;
    logic [WIDTH-1:0] mem_q;
    logic             busy;
    logic             done;
    logic             cmd_err;

    typedef struct {
        logic [DEPTH-1:0] addr;
        logic [WIDTH-1:0] data;
        logic             last;
    } wr_t;

    wr_t              exp_wr_q[$];
    logic [7:0]       exp_tx_q[$];
    logic [WIDTH-1:0] model_mem[N_WORDS];
    logic [WIDTH-1:0] ram[1 << DEPTH];
    logic [7:0]       pay[$];

    int unsigned n_vec = 0, n_err = 0;
    int unsigned exp_done = 0, got_done = 0, exp_err = 0, got_err = 0;
    int unsigned cyc = 0, rd_cyc = 0;
    bit          first_tx_pending = 1'b0;
    bit          awaiting_done = 1'b0;
    wr_t         mon_e;
    logic [7:0]  mon_b;
    logic [7:0]  held;

    uart_mem_sequencer #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .N_WORDS(N_WORDS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .tx_done  (tx_done),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_wr_en(mem_wr_en),
        .mem_q    (mem_q),
        .busy     (busy),
        .done     (done),
        .cmd_err  (cmd_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment RAM: synchronous read, data one cycle after the address.
    always @(posedge clk) begin
        if (mem_wr_en) ram[mem_addr] <= mem_data;
        mem_q <= ram[mem_addr];
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT strobes an output.
    always @(negedge clk) begin
        if (reset) begin
            if (tx_done) awaiting_done = 1'b0;
            if (mem_wr_en) begin
                check("wr_expected", 32'(exp_wr_q.size() != 0), 1);
                if (exp_wr_q.size() != 0) begin
                    mon_e = exp_wr_q.pop_front();
                    check("wr_addr", WIDTH'(mem_addr), WIDTH'(mon_e.addr));
                    check("wr_data", mem_data, mon_e.data);
                    check("done_with_wr", WIDTH'(done), WIDTH'(mon_e.last));
                end
            end
            if (tx_start) begin
                check("tx_after_prev_done", WIDTH'(awaiting_done), 0);
                awaiting_done = 1'b1;
                if (first_tx_pending) begin
                    check("rd_latency", cyc - rd_cyc, 3);
                    first_tx_pending = 1'b0;
                end
                check("tx_expected", 32'(exp_tx_q.size() != 0), 1);
                if (exp_tx_q.size() != 0) begin
                    mon_b = exp_tx_q.pop_front();
                    check("tx_data", WIDTH'(tx_data), WIDTH'(mon_b));
                end
            end
            if (done)    got_done++;
            if (cmd_err) got_err++;
        end
    end

    // UART TX responder: random bit-time, checks tx_data holds until tx_done.
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (reset && tx_start) begin
                held = tx_data;
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1 tx_done = 1'b1;
                @(negedge clk);
                check("tx_hold", WIDTH'(tx_data), WIDTH'(held));
                @(posedge clk);
                #1 tx_done = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic wait_idle();
        int unsigned t;
        t = 0;
        while ((busy || exp_wr_q.size() != 0 || exp_tx_q.size() != 0) && t < 3000) begin
            tick();
            t++;
        end
        check("txn_complete", 32'(t < 3000), 1);
        repeat (3) tick();
    endtask

    function automatic logic [WIDTH-1:0] pack_word(input int unsigned w);
        logic [WIDTH-1:0] word;
        word = '0;
        for (int unsigned k = 0; k < BPW; k++)
            word = word | (WIDTH'(pay[w * BPW + k]) << (8 * k));
        return word;
    endfunction

    task automatic do_write(input int unsigned max_gap);
        wr_t        e;
        logic [7:0] x;
        x = '0;
        for (int unsigned i = 0; i < N_WORDS * BPW; i++) x = x ^ pay[i];
        for (int unsigned w = 0; w < N_WORDS; w++) begin
            model_mem[w] = pack_word(w);
            e.addr = DEPTH'(w);
            e.data = model_mem[w];
`ifdef UART_MEM_CHECKSUM_EN
            e.last = 1'b0;
`else
            e.last = (w == N_WORDS - 1);
`endif
            exp_wr_q.push_back(e);
        end
`ifdef UART_MEM_CHECKSUM_EN
        exp_tx_q.push_back(x);
`endif
        exp_done++;
        send_byte(8'h57, $urandom_range(0, max_gap));
        for (int unsigned i = 0; i < N_WORDS * BPW; i++)
            send_byte(pay[i], (i == N_WORDS * BPW - 1) ? 0 : $urandom_range(0, max_gap));
        wait_idle();
    endtask

    task automatic do_read(input bit inject);
        logic [7:0] b, x;
        x = '0;
        for (int unsigned w = 0; w < N_WORDS; w++)
            for (int unsigned k = 0; k < BPW; k++) begin
                b = 8'(model_mem[w] >> (8 * k));
                exp_tx_q.push_back(b);
                x = x ^ b;
            end
`ifdef UART_MEM_CHECKSUM_EN
        exp_tx_q.push_back(x);
`endif
        exp_done++;
        first_tx_pending = 1'b1;
        rd_cyc = cyc;
        send_byte(8'h52, 0);
        if (inject) send_byte(8'h57, 0);
        wait_idle();
    endtask

    initial begin
        reset   = 1'b0;
        rx_done = 1'b0;
        rx_data = '0;
        repeat (3) tick();
        check("rst_tx_start", WIDTH'(tx_start), 0);
        check("rst_tx_data", WIDTH'(tx_data), 0);
        check("rst_mem_addr", WIDTH'(mem_addr), 0);
        check("rst_mem_data", mem_data, 0);
        check("rst_mem_wr_en", WIDTH'(mem_wr_en), 0);
        check("rst_busy", WIDTH'(busy), 0);
        check("rst_done", WIDTH'(done), 0);
        check("rst_cmd_err", WIDTH'(cmd_err), 0);
        reset = 1'b1;
        tick();

        // Abort mid-LOAD: word 0 completes and is written, word 1 is discarded.
        pay.delete();
        for (int unsigned i = 0; i < 6; i++) pay.push_back(8'hA0 + 8'(i));
        begin
            wr_t e;
            model_mem[0] = pack_word(0);
            e.addr = '0;
            e.data = model_mem[0];
            e.last = 1'b0;
            exp_wr_q.push_back(e);
        end
        send_byte(8'h57, 0);
        for (int unsigned i = 0; i < 6; i++) send_byte(pay[i], 1);
        reset = 1'b0;
        #1;
        check("abort_busy", WIDTH'(busy), 0);
        check("abort_wr_en", WIDTH'(mem_wr_en), 0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (3) tick();
        check("abort_wr_drained", exp_wr_q.size(), 0);

        // Sequential payload, back-to-back bytes (rx_done coincides with mem_wr_en).
        pay.delete();
        for (int unsigned i = 0; i < N_WORDS * BPW; i++) pay.push_back(8'(i));
        do_write(0);
        do_read(1'b1);

        // Unknown command, then a normal read.
        exp_err++;
        send_byte(8'h41, 0);
        repeat (2) tick();
        check("bad_cmd_busy", WIDTH'(busy), 0);
        check("bad_cmd_err_seen", got_err, exp_err);
        do_read(1'b0);

        // Checksum-oriented payloads.
        pay.delete();
        for (int unsigned i = 0; i < N_WORDS * BPW; i++) pay.push_back(8'h01);
        do_write(1);
        do_read(1'b0);
        pay.delete();
        for (int unsigned i = 0; i < N_WORDS * BPW; i++) pay.push_back((i == 0) ? 8'h01 : 8'h00);
        do_write(2);
        do_read(1'b0);

        // Randomized payloads and gaps.
        for (int unsigned r = 0; r < 4; r++) begin
            pay.delete();
            for (int unsigned i = 0; i < N_WORDS * BPW; i++) pay.push_back(8'($urandom));
            do_write(3);
            do_read(r[0]);
        end

        check("done_count", got_done, exp_done);
        check("cmd_err_count", got_err, exp_err);
        check("wr_queue_empty", exp_wr_q.size(), 0);
        check("tx_queue_empty", exp_tx_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_mem_sequencer.md
Name: uart_mem_sequencer

Overview:
- Controller between the UART receiver/transmitter pair and a single-port word memory (WIDTH-bit words, DEPTH-bit address).
- Decodes a one-byte command from the UART RX stream:
  - 'W' (0x57): packs the following bytes into words and writes them to sequential addresses.
  - 'R' (0x52): reads words back and streams them out byte by byte through the UART TX.
- Replaces the fixed RX-to-memory/TX loopback wiring; drives the memory address, write enable and TX start.

Parameters:
- WIDTH, 32, memory word width; must be a multiple of 8.
- DEPTH, 8, memory address width in bits.
- N_WORDS, 8, words per W/R transaction; 1 ≤ N_WORDS ≤ 2^DEPTH.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx_data  input  8  received byte from UART receiver.
- rx_done  input  1  one-cycle pulse; rx_data valid in that cycle.
- tx_done  input  1  one-cycle pulse when the transmitter finishes a byte.
- tx_start  output  1  one-cycle pulse launching transmission of tx_data.
- tx_data  output  8  byte to transmit; held stable from tx_start until tx_done.
- mem_addr  output  DEPTH  memory address.
- mem_data  output  WIDTH  memory write data.
- mem_wr_en  output  1  one-cycle memory write strobe.
- mem_q  input  WIDTH  memory read data, valid 1 cycle after mem_addr is presented.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse at the end of a W or R transaction.
- cmd_err  output  1  one-cycle pulse when an unknown command byte is received in IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs, counters and shift registers are 0.
- Byte order: words are packed and unpacked LSB byte first; byte k occupies bits [8k+7:8k]; BPW = WIDTH/8.
- State machine: IDLE, LOAD, RD_ADDR, RD_WAIT, TX_SEND, TX_WAIT.
- IDLE:
  - rx_done with 0x57 → LOAD; word_cnt=0, byte_cnt=0.
  - rx_done with 0x52 → RD_ADDR; word_cnt=0.
  - rx_done with any other byte → cmd_err pulse next cycle, stay in IDLE.
- LOAD:
  - Each rx_done shifts rx_data into the word buffer at position byte_cnt.
  - On the byte where byte_cnt==BPW-1: the next cycle has mem_data=assembled word, mem_addr=word_cnt, mem_wr_en=1 for exactly one cycle; byte_cnt→0; word_cnt increments.
  - The write cycle does not block reception: an rx_done coinciding with mem_wr_en is accepted as byte 0 of the next word.
  - After word N_WORDS-1 is written → IDLE, done pulse in the same cycle as the final mem_wr_en.
- RD_ADDR: mem_addr=word_cnt → RD_WAIT (1 cycle).
- RD_WAIT: capture mem_q into the shift buffer, byte_cnt=0 → TX_SEND.
- TX_SEND: tx_data=buffer byte byte_cnt; tx_start=1 for one cycle → TX_WAIT.
- TX_WAIT: on tx_done:
  - if byte_cnt<BPW-1: byte_cnt++ → TX_SEND.
  - else if word_cnt<N_WORDS-1: word_cnt++ → RD_ADDR.
  - else → IDLE with done pulse.
- rx_done during R states is ignored; the byte is dropped.
- mem_wr_en is never asserted outside LOAD.
- Counters: word_cnt is DEPTH+1 bits so N_WORDS=2^DEPTH does not overflow; mem_addr is word_cnt[DEPTH-1:0].
- Reset asserted mid-transaction aborts immediately; a partially assembled word is discarded and not written.
- Latency:
  - 'R' rx_done to first tx_start: 3 cycles (IDLE→RD_ADDR→RD_WAIT→TX_SEND).
  - Last W byte to its mem_wr_en: 1 cycle.

Optional Feature:
- Macro UART_MEM_CHECKSUM_EN.
- Defined:
  - The sequencer keeps an 8-bit running XOR of all payload bytes, reset at each command.
  - After the last R byte's tx_done, it sends one extra byte (the XOR of all transmitted bytes), then returns to IDLE; done pulses after that tx_done.
  - After a W transaction, it transmits the XOR of the received payload as a single acknowledge byte; done pulses after its tx_done.
- Undefined: no checksum logic or extra bytes; behaviour exactly as above.

Decomposition:
- Shared package holds:
  - State encoding localparams.
  - Command constants CMD_WRITE=8'h57, CMD_READ=8'h52.
- One natural sub-module: uart_word_packer (byte↔word shift buffer with byte_cnt and a full/empty flag), instanced once and used for both packing and unpacking.
- FSM and counters stay in uart_mem_sequencer.

Test Plan:
- Reset mid-LOAD after 6 bytes → busy=0, no mem_wr_en; a new 'W' restarts at address 0.
- 'W' then bytes 0x00..0x1F (N_WORDS=8, WIDTH=32) → 8 writes:
  - addr 0 data 0x03020100, …, addr 7 data 0x1F1E1D1C.
  - done with the 8th mem_wr_en.
- 'R' after the above → 32 tx_start pulses with tx_data 0x00..0x1F in order; each tx_start only after the previous tx_done; first tx_start 3 cycles after rx_done.
- Unknown command 0x41 → cmd_err pulse, state stays IDLE, no memory/TX activity; a following 'R' works normally.
- rx_done in the same cycle as mem_wr_en during LOAD → byte is retained as byte 0 of the next word; verify written data.
- With UART_MEM_CHECKSUM_EN and payload 0x00..0x1F:
  - 'R' sends a 33rd byte 0x00 (XOR of 0..31).
  - 'W' acknowledges with 0x00.
  - Payload 0x01 repeated 32× gives 0x00; payload 0x01 then 0x00×31 gives 0x01.
